// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-lane round-robin broadcast bus arbiter.
package bus_arb_pkg;

   localparam int unsigned ID_W     = 8;
   localparam int unsigned PCKG_MAX = 1024;
   localparam int unsigned PCKG_AW  = $clog2(PCKG_MAX);

   typedef enum logic [0:0] {IDLE, DELIVER} lane_state_t;

   // Destination ID is the top ID_W bits of an sz-bit package.
   function automatic logic [ID_W-1:0] pckg_dst(input logic [PCKG_MAX-1:0] pckg,
                                                input int unsigned         sz);
      logic [PCKG_AW-1:0] msb;
      msb = PCKG_AW'(sz - 1);
      return pckg[msb -: ID_W];
   endfunction

endpackage

// File: rtl/bus_lane_arbiter.sv
// One bus lane: round-robin grant, package capture, destination decode and
// saturating drop counter.
module bus_lane_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned     drvrs     = 4,
   parameter int unsigned     pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [drvrs-1:0]                pndng_i,
   input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop_i,
   output logic [drvrs-1:0]                pop_o,
   output logic [drvrs-1:0]                push_o,
   output logic [pckg_sz-1:0]              d_push_o,
   output logic                            lane_busy_o,
   output logic [15:0]                     err_cnt_o
);

   localparam int unsigned GW = $clog2(drvrs);

   lane_state_t        state_q, state_d;
   logic [GW-1:0]      last_grant_q, last_grant_d;
   logic [GW-1:0]      src_q, src_d;
   logic [pckg_sz-1:0] pckg_q, pckg_d;
   logic [drvrs-1:0]   dst_mask_q, dst_mask_d;
   logic               dst_bad_q, dst_bad_d;
   logic [15:0]        err_cnt_q, err_cnt_d;

   logic [GW-1:0]      grant;
   logic               grant_vld;
   logic [ID_W-1:0]    dst;
   int unsigned        cand;

   // First requester strictly after last_grant_q, searching upward with wrap.
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      cand      = 0;
      for (int unsigned i = 1; i <= drvrs; i++) begin
         cand = (32'(last_grant_q) + i) % drvrs;
         if (!grant_vld && pndng_i[GW'(cand)]) begin
            grant_vld = 1'b1;
            grant     = GW'(cand);
         end
      end
   end

   assign dst = pckg_dst(PCKG_MAX'(d_pop_i[grant]), pckg_sz);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      src_d        = src_q;
      pckg_d       = pckg_q;
      dst_mask_d   = dst_mask_q;
      dst_bad_d    = dst_bad_q;
      err_cnt_d    = err_cnt_q;
      pop_o        = '0;
      push_o       = '0;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               pop_o[grant] = 1'b1;
               pckg_d       = d_pop_i[grant];
               src_d        = grant;
               dst_mask_d   = '0;
               dst_bad_d    = 1'b0;
               if (32'(dst) < drvrs) begin
                  dst_mask_d[GW'(dst)] = 1'b1;
               end else if (dst == broadcast) begin
                  dst_mask_d        = '1;
                  dst_mask_d[grant] = 1'b0;
               end else begin
                  dst_bad_d = 1'b1;
               end
               state_d = DELIVER;
            end
         end
         DELIVER: begin
            push_o = dst_mask_q;
            if (dst_bad_q && (err_cnt_q != 16'hFFFF)) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
            last_grant_d = src_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Strobes are suppressed while reset is held, even mid-delivery.
      if (reset_i) begin
         pop_o  = '0;
         push_o = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         last_grant_q <= GW'(drvrs - 1);
         src_q        <= '0;
         pckg_q       <= '0;
         dst_mask_q   <= '0;
         dst_bad_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         src_q        <= src_d;
         pckg_q       <= pckg_d;
         dst_mask_q   <= dst_mask_d;
         dst_bad_q    <= dst_bad_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign d_push_o    = pckg_q;
   assign lane_busy_o = (state_q == DELIVER) && !reset_i;
   assign err_cnt_o   = err_cnt_q;

endmodule

// File: rtl/bus_rr_bcast_arbiter.sv
// Multi-lane bus arbiter: one independent bus_lane_arbiter per lane; this level
// only maps the flattened lane arrays onto the lane instances.
module bus_rr_bcast_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned     bits      = 1,
   parameter int unsigned     drvrs     = 4,
   parameter int unsigned     pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = {8{1'b1}}
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [bits-1:0][drvrs-1:0]               pndng,
   input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
   output logic [bits-1:0][drvrs-1:0]               pop,
   output logic [bits-1:0][drvrs-1:0]               push,
   output logic [bits-1:0][pckg_sz-1:0]             D_push,
   output logic [bits-1:0]                          lane_busy,
   output logic [bits-1:0][15:0]                    err_cnt
);

   for (genvar l = 0; l < bits; l++) begin : g_lane
      bus_lane_arbiter #(
         .drvrs     (drvrs),
         .pckg_sz   (pckg_sz),
         .broadcast (broadcast)
      ) u_lane (
         .clk_i       (clk),
         .reset_i     (reset),
         .pndng_i     (pndng[l]),
         .d_pop_i     (D_pop[l]),
         .pop_o       (pop[l]),
         .push_o      (push[l]),
         .d_push_o    (D_push[l]),
         .lane_busy_o (lane_busy[l]),
         .err_cnt_o   (err_cnt[l])
      );
   end

endmodule

// File: tb/tb_bus_rr_bcast_arbiter.sv
// Scoreboard bench for bus_rr_bcast_arbiter: device FIFOs and arbitration are
// modelled with queues; a negedge monitor compares the DUT against expectations.
module tb_bus_rr_bcast_arbiter;

   localparam int unsigned BITS = 2;
   localparam int unsigned DRV  = 4;
   localparam int unsigned PW   = 16;

   typedef struct {
      logic [DRV-1:0] mask;
      logic [PW-1:0]  data;
      logic [15:0]    err;
   } dlv_t;

   logic                            clk   = 1'b0;
   logic                            reset = 1'b1;
   logic [BITS-1:0][DRV-1:0]        pndng = '0;
   logic [BITS-1:0][DRV-1:0][PW-1:0] D_pop = '0;
   logic [BITS-1:0][DRV-1:0]        pop;
   logic [BITS-1:0][DRV-1:0]        push;
   logic [BITS-1:0][PW-1:0]         D_push;
   logic [BITS-1:0]                 lane_busy;
   logic [BITS-1:0][15:0]           err_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   logic [PW-1:0]  fifo_m    [BITS][DRV][$];
   logic [DRV-1:0] exp_pop_q [BITS][$];
   dlv_t           dlv_q     [BITS][$];
   int             last_m    [BITS];
   bit             busy_m    [BITS];
   int unsigned    err_m     [BITS];

   bus_rr_bcast_arbiter #(
      .bits      (BITS),
      .drvrs     (DRV),
      .pckg_sz   (PW),
      .broadcast (8'hFF)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pndng     (pndng),
      .D_pop     (D_pop),
      .pop       (pop),
      .push      (push),
      .D_push    (D_push),
      .lane_busy (lane_busy),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endfunction

   // Reference: a lane alternates between an arbitration slot and a delivery slot.
   function automatic void predict(int l, bit r);
      logic [DRV-1:0] e;
      e = '0;
      if (r) begin
         busy_m[l] = 1'b0;
         last_m[l] = DRV - 1;
         err_m[l]  = 0;
      end else if (busy_m[l]) begin
         busy_m[l] = 1'b0;
      end else begin
         for (int i = 1; i <= DRV; i++) begin
            int d;
            d = (last_m[l] + i) % DRV;
            if (fifo_m[l][d].size() > 0) begin
               logic [PW-1:0] p;
               int            id;
               dlv_t          x;
               p         = fifo_m[l][d].pop_front();
               id        = int'(p[PW-1 -: 8]);
               e[d]      = 1'b1;
               busy_m[l] = 1'b1;
               last_m[l] = d;
               x.data    = p;
               x.err     = 16'(err_m[l]);
               if (id < DRV) x.mask = DRV'(1) << id;
               else if (id == 255) x.mask = ~(DRV'(1) << d);
               else begin
                  x.mask = '0;
                  if (err_m[l] < 65535) err_m[l]++;
               end
               dlv_q[l].push_back(x);
               break;
            end
         end
      end
      exp_pop_q[l].push_back(e);
   endfunction

   task automatic step(input bit r);
      @(posedge clk);
      #1;
      reset = r;
      for (int l = 0; l < BITS; l++) begin
         for (int d = 0; d < DRV; d++) begin
            pndng[l][d] = fifo_m[l][d].size() > 0;
            D_pop[l][d] = pndng[l][d] ? fifo_m[l][d][0] : '0;
         end
      end
      for (int l = 0; l < BITS; l++) predict(l, r);
   endtask

   function automatic bit model_active();
      for (int l = 0; l < BITS; l++) begin
         if (busy_m[l]) return 1'b1;
         for (int d = 0; d < DRV; d++) if (fifo_m[l][d].size() > 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (model_active() && n < 500) begin
         step(1'b0);
         n++;
      end
      step(1'b0);
      step(1'b0);
   endtask

   always @(negedge clk) begin : mon
      logic [DRV-1:0] ep;
      dlv_t           e;
      for (int l = 0; l < BITS; l++) begin
         if (exp_pop_q[l].size() > 0) begin
            ep = exp_pop_q[l].pop_front();
            chk($sformatf("pop[%0d]", l), 32'(pop[l]), 32'(ep));
         end
         if (reset) begin
            chk($sformatf("rst_busy[%0d]", l), 32'(lane_busy[l]), 0);
            chk($sformatf("rst_push[%0d]", l), 32'(push[l]), 0);
            dlv_q[l].delete();
         end else if (lane_busy[l]) begin
            if (dlv_q[l].size() == 0) begin
               n_chk++;
               $display("FAIL dlv[%0d]: lane busy with push %0h, no delivery expected", l,
                        push[l]);
            end else begin
               e = dlv_q[l].pop_front();
               chk($sformatf("push[%0d]", l), 32'(push[l]), 32'(e.mask));
               chk($sformatf("D_push[%0d]", l), 32'(D_push[l]), 32'(e.data));
               chk($sformatf("err_cnt[%0d]", l), 32'(err_cnt[l]), 32'(e.err));
            end
         end else begin
            chk($sformatf("idle_push[%0d]", l), 32'(push[l]), 0);
         end
      end
   end

   initial begin
      for (int l = 0; l < BITS; l++) begin
         last_m[l] = DRV - 1;
         busy_m[l] = 1'b0;
         err_m[l]  = 0;
      end

      // Reset with everything pending, then continuous round-robin to device 0.
      for (int k = 0; k < 2; k++)
         for (int d = 0; d < DRV; d++) fifo_m[0][d].push_back({8'h00, 8'(8'hA0 + d)});
      repeat (3) step(1'b1);
      chk("err_cnt_rst", 32'(err_cnt[0]), 0);
      drain();

      // Unicast and broadcast.
      fifo_m[0][1].push_back(16'h0355);
      drain();
      fifo_m[0][2].push_back(16'hFFA5);
      drain();

      // Invalid destination, then saturation from a preloaded counter.
      repeat (3) fifo_m[0][0].push_back(16'h0711);
      drain();
      chk("err_cnt_3", 32'(err_cnt[0]), 3);
      dut.g_lane[0].u_lane.err_cnt_q = 16'hFFFF;
      err_m[0] = 65535;
      fifo_m[0][0].push_back(16'h0711);
      drain();
      chk("err_cnt_sat", 32'(err_cnt[0]), 32'hFFFF);

      // Reset landing in the delivery cycle drops the package.
      fifo_m[0][1].push_back(16'h0222);
      step(1'b0);
      step(1'b1);
      drain();
      chk("err_cnt_mid_rst", 32'(err_cnt[0]), 0);

      // Random traffic on both lanes at once.
      for (int c = 0; c < 400; c++) begin
         for (int l = 0; l < BITS; l++) begin
            for (int d = 0; d < DRV; d++) begin
               if ($urandom_range(0, 3) == 0 && fifo_m[l][d].size() < 3) begin
                  int          sel;
                  logic [7:0]  id;
                  sel = int'($urandom_range(0, 5));
                  if (sel < 4) id = 8'(sel);
                  else if (sel == 4) id = 8'hFF;
                  else id = 8'($urandom_range(4, 254));
                  fifo_m[l][d].push_back({id, 8'($urandom)});
               end
            end
         end
         step(1'b0);
      end
      drain();

      @(negedge clk);
      #1;
      for (int l = 0; l < BITS; l++) begin
         chk($sformatf("err_final[%0d]", l), 32'(err_cnt[l]), 32'(err_m[l]));
         chk($sformatf("dlv_left[%0d]", l), 32'(dlv_q[l].size()), 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bus_rr_bcast_arbiter.md
# bus_rr_bcast_arbiter

Parametrised multi-lane bus arbiter that moves packages between `drvrs` device FIFOs on each of `bits` independent bus lanes. It sits between the per-device driver/monitor FIFOs and the verification environment, in the place of the single-lane bus generator/arbiter. Compared with that block it adds:
- round-robin fairness per lane;
- broadcast delivery that excludes the source device;
- drop-and-count of packages addressed to a nonexistent device;
- per-lane busy reporting.

## Interface

Parameters:
- `bits`, 1, number of independent bus lanes.
- `drvrs`, 4, devices per lane; 2..255.
- `pckg_sz`, 16, package width in bits; minimum 9.
- `broadcast`, `{8{1'b1}}`, destination ID meaning "all devices".

Ports (all arrays indexed `[lane][device]`):
- `clk`, in, 1. Single clock, rising edge.
- `reset`, in, 1. Synchronous, active-high.
- `pndng`, in, `bits x drvrs`. Device FIFO is non-empty.
- `D_pop`, in, `bits x drvrs x pckg_sz`. Head of the device FIFO, valid while `pndng` is high.
- `pop`, out, `bits x drvrs`. One-cycle pop strobe to the device FIFO.
- `push`, out, `bits x drvrs`. One-cycle push strobe to the device input FIFO.
- `D_push`, out, `bits x pckg_sz`. Package driven on the lane; shared by all devices on that lane.
- `lane_busy`, out, `bits`. Lane holds a captured package.
- `err_cnt`, out, `bits x 16`. Dropped-package count per lane, saturating.

## Operation

Package format:
- Destination ID is `pckg[pckg_sz-1 -: 8]`; the remaining bits are payload and pass through untouched.

Lane FSM (one independent copy per lane):
- IDLE:
  - If any `pndng[l]` bit is set, grant the first requester strictly after `last_grant`, searching upward with wrap.
  - In the same cycle, assert `pop[l][g]` and register `D_pop[l][g]`, `g` and the decoded destination. Go to DELIVER.
  - With no requester, stay in IDLE with all strobes low.
- DELIVER:
  - ID < `drvrs`: assert `push[l][ID]`. A package addressed to its own source is delivered normally.
  - ID == `broadcast`: assert `push[l][k]` for every `k != g`.
  - Any other ID: assert no push and increment `err_cnt[l]`, saturating at 16'hFFFF.
  - Set `last_grant = g` and return to IDLE.
- `D_push[l]` holds the captured package during DELIVER and keeps its last value otherwise.
- Lanes share no state; simultaneous activity on different lanes is independent.

## Timing

Reset values:
- `pop`, `push`, `D_push`, `lane_busy`, `err_cnt` = 0.
- FSM = IDLE.
- `last_grant` = `drvrs-1`, so device 0 wins the first arbitration.

Latency and throughput:
- `pop` is asserted in cycle N (IDLE), and `push`/`D_push` are valid in cycle N+1 (DELIVER).
- The next `pop` on that lane comes no earlier than N+2.
- Peak throughput is one package per 2 cycles per lane.

Handshake:
- A device FIFO must present a valid `D_pop` combinationally whenever `pndng` is high.
- The arbiter never pops a device whose `pndng` is low.
- At most one `pop` bit per lane is high in any cycle.
- `lane_busy[l]` is high exactly in DELIVER.

Boundary conditions:
- Single requester: it is granted on every arbitration slot, regardless of `last_grant`.
- `last_grant == drvrs-1`: the search wraps to device 0.
- `pndng` dropping in DELIVER has no effect; the package is already captured.
- `reset` in DELIVER: push is suppressed that cycle, the captured package is lost, and all state returns to reset values.
- Sink back-pressure is not modelled; device input FIFOs must accept every push.

## Structure

- Package `bus_arb_pkg` holds:
  - `ID_W = 8`;
  - the `lane_state_t` enum {IDLE, DELIVER};
  - a function returning the destination field of a package.
- Sub-module `bus_lane_arbiter`: one lane (FSM, round-robin pointer, capture register, decode, error counter). Parameters are `drvrs`, `pckg_sz`, `broadcast`.
- The top level instantiates `bits` copies of `bus_lane_arbiter` in a generate loop and only flattens the port arrays.

## Test plan

1. **Reset:** hold `reset` for 3 cycles with all `pndng` high → `pop`, `push`, `err_cnt` and `lane_busy` stay 0. On release, the first pop goes to device 0.
2. **Unicast:** device 1 holds 16'h0355 → `pop[0][1]` at N, then `push[0][3]` with `D_push = 16'h0355` at N+1, with no other push bits set.
3. **Round-robin:** devices 0–3 pending continuously, each addressed to device 0 → pop order 0,1,2,3,0, with one pop every 2 cycles.
4. **Broadcast:** device 2 sends 16'hFFA5 → `push[0] = 4'b1011` for one cycle, and `D_push = 16'hFFA5`.
5. **Invalid ID:** device 0 sends 16'h0711 three times → no push, and `err_cnt[0] = 3`. Preload the counter to 16'hFFFF and send once more → it stays 16'hFFFF.
6. **Reset mid-operation and lane independence:** assert `reset` in DELIVER → no push that cycle and the package is dropped. With `bits = 2`, traffic on both lanes at once → each lane shows independent, correct timing.
